// File: rtl/d2_uop_queue_if.sv
// Uop stream bundle shared by the d2 -> queue and queue -> rename sides.
// The master drives valid and the uop fields; the slave drives ready.
interface d2_uop_queue_if;
  logic        valid;
  logic        ready;
  logic [31:0] uop;
  logic        eoi;
  logic [4:0]  dr;
  logic [4:0]  sr1;
  logic [4:0]  sr2;
  logic [31:0] imm;
  logic        use_imm;
  logic [31:0] pc;
  logic        exception;

  modport master (
    output valid, uop, eoi, dr, sr1, sr2, imm, use_imm, pc, exception,
    input  ready
  );

  modport slave (
    input  valid, uop, eoi, dr, sr1, sr2, imm, use_imm, pc, exception,
    output ready
  );
endinterface

// File: rtl/d2_uop_queue.sv
// Micro-op buffer between d2 decode and rename. Holds uops in order and only
// releases the head once its whole instruction (through eoi) is buffered, so
// rename never observes a partial multi-uop instruction.
module d2_uop_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  d2_uop_queue_if.slave      in_if,
  d2_uop_queue_if.master     out_if,
  output logic [PTR_W:0]     count
);

  localparam int ENT_W = 114;
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   inst_cnt;

  logic             push;
  logic             pop;
  logic             stored_eoi;
  logic             head_eoi;
  logic [ENT_W-1:0] wr_data;

  // An excepting uop always closes its instruction so it can never strand
  // the head waiting for an eoi that will not come.
  assign stored_eoi = in_if.eoi | in_if.exception;

  assign wr_data = {in_if.uop, stored_eoi, in_if.dr, in_if.sr1, in_if.sr2,
                    in_if.imm, in_if.use_imm, in_if.pc, in_if.exception};

  // Ready depends on state only; a full queue stalls d2 even while popping.
  assign in_if.ready = (count != FULL);

  // The full override keeps a stream that never sends eoi from deadlocking.
  assign out_if.valid = (count != '0) && ((inst_cnt != '0) || (count == FULL));

  assign push = in_if.valid & in_if.ready;
  assign pop  = out_if.valid & out_if.ready;

  // Zero-latency head read.
  assign {out_if.uop, out_if.eoi, out_if.dr, out_if.sr1, out_if.sr2,
          out_if.imm, out_if.use_imm, out_if.pc, out_if.exception} = mem[head];

  assign head_eoi = mem[head][81];

  // Entry storage: written at the tail on an accepted push, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[tail] <= wr_data;
    end
  end

  // Pointers and occupancy; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Number of complete instructions held, tracked by eoi entries in and out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_cnt <= '0;
    end else if (flush) begin
      inst_cnt <= '0;
    end else begin
      if ((push && stored_eoi) && !(pop && head_eoi)) begin
        inst_cnt <= inst_cnt + 1'b1;
      end else if ((pop && head_eoi) && !(push && stored_eoi)) begin
        inst_cnt <= inst_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_d2_uop_queue.sv
// Bench for d2_uop_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_d2_uop_queue;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [3:0] count;

  d2_uop_queue_if in_bus ();
  d2_uop_queue_if out_bus ();

  d2_uop_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_if  (in_bus),
    .out_if (out_bus),
    .count  (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of uops as the consumer should see them.
  typedef struct {
    logic [31:0] uop;
    logic        eoi;
    logic [4:0]  dr;
    logic [4:0]  sr1;
    logic [4:0]  sr2;
    logic [31:0] imm;
    logic        use_imm;
    logic [31:0] pc;
    logic        exception;
  } ent_t;

  ent_t q[$];

  function automatic logic m_in_ready();
    return q.size() != DEPTH;
  endfunction

  function automatic logic m_out_valid();
    logic any_eoi = 1'b0;
    foreach (q[i]) if (q[i].eoi) any_eoi = 1'b1;
    return (q.size() != 0) && (any_eoi || q.size() == DEPTH);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      logic do_push, do_pop;
      ent_t e;
      do_push = in_bus.valid && m_in_ready();
      do_pop  = m_out_valid() && out_bus.ready;
      e.uop = in_bus.uop; e.eoi = in_bus.eoi | in_bus.exception;
      e.dr = in_bus.dr; e.sr1 = in_bus.sr1; e.sr2 = in_bus.sr2;
      e.imm = in_bus.imm; e.use_imm = in_bus.use_imm; e.pc = in_bus.pc;
      e.exception = in_bus.exception;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  // Compare DUT against the model once per cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("m_count", 128'(count), 128'(q.size()));
    chk("m_in_ready", 128'(in_bus.ready), 128'(m_in_ready()));
    chk("m_out_valid", 128'(out_bus.valid), 128'(m_out_valid()));
    if (m_out_valid()) begin
      chk("m_head_fields",
          128'({out_bus.uop, out_bus.eoi, out_bus.dr, out_bus.sr1, out_bus.sr2,
                out_bus.imm, out_bus.use_imm, out_bus.pc, out_bus.exception}),
          128'({q[0].uop, q[0].eoi, q[0].dr, q[0].sr1, q[0].sr2,
                q[0].imm, q[0].use_imm, q[0].pc, q[0].exception}));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] u, input logic e,
                     input logic x, input logic [31:0] p);
    in_bus.valid     = v;
    in_bus.uop       = u;
    in_bus.eoi       = e;
    in_bus.exception = x;
    in_bus.pc        = p;
    in_bus.dr        = u[4:0];
    in_bus.sr1       = u[4:0] + 5'd1;
    in_bus.sr2       = u[4:0] + 5'd2;
    in_bus.imm       = {u[15:0], ~u[15:0]};
    in_bus.use_imm   = u[1];
  endtask

  initial begin
    put(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    out_bus.ready = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_out_valid", 128'(out_bus.valid), 128'd0);
    chk("rst_in_ready", 128'(in_bus.ready), 128'd1);
    chk("rst_out_uop", 128'(out_bus.uop), 128'd0);
    #20 rst = 1'b1;
    cyc();

    // single-uop instruction
    put(1'b1, 32'h11, 1'b1, 1'b0, 32'h100);
    cyc();
    put(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t1_out_valid", 128'(out_bus.valid), 128'd1);
    chk("t1_out_uop", 128'(out_bus.uop), 128'h11);
    chk("t1_out_pc", 128'(out_bus.pc), 128'h100);
    chk("t1_count", 128'(count), 128'd1);
    out_bus.ready = 1'b1;
    cyc();
    chk("t1_pop_count", 128'(count), 128'd0);
    chk("t1_pop_valid", 128'(out_bus.valid), 128'd0);

    // 3-uop instruction held until eoi, then drained in order
    put(1'b1, 32'h21, 1'b0, 1'b0, 32'h200);
    cyc();
    chk("t2_u1_valid", 128'(out_bus.valid), 128'd0);
    put(1'b1, 32'h22, 1'b0, 1'b0, 32'h200);
    cyc();
    chk("t2_u2_valid", 128'(out_bus.valid), 128'd0);
    chk("t2_u2_count", 128'(count), 128'd2);
    put(1'b1, 32'h23, 1'b1, 1'b0, 32'h200);
    cyc();
    put(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t2_u3_valid", 128'(out_bus.valid), 128'd1);
    chk("t2_u3_count", 128'(count), 128'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_drain_uop", 128'(out_bus.uop), 128'(32'h21 + i));
      cyc();
    end
    chk("t2_empty", 128'(count), 128'd0);

    // exception terminates its instruction
    out_bus.ready = 1'b0;
    put(1'b1, 32'h31, 1'b0, 1'b1, 32'h300);
    cyc();
    put(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t3_valid", 128'(out_bus.valid), 128'd1);
    chk("t3_eoi", 128'(out_bus.eoi), 128'd1);
    chk("t3_exception", 128'(out_bus.exception), 128'd1);
    out_bus.ready = 1'b1;
    cyc();
    out_bus.ready = 1'b0;

    // fill to full, ninth push held off, pointer wrap
    for (int i = 0; i < 8; i++) begin
      put(1'b1, 32'h40 + i, 1'b1, 1'b0, 32'h400 + 4 * i);
      cyc();
    end
    put(1'b1, 32'h48, 1'b1, 1'b0, 32'h420);
    chk("t4_full_count", 128'(count), 128'd8);
    chk("t4_full_in_ready", 128'(in_bus.ready), 128'd0);
    cyc();
    chk("t4_ignored_count", 128'(count), 128'd8);
    chk("t4_head", 128'(out_bus.uop), 128'h40);
    out_bus.ready = 1'b1;
    cyc();
    out_bus.ready = 1'b0;
    chk("t4_pop_count", 128'(count), 128'd7);
    chk("t4_pop_in_ready", 128'(in_bus.ready), 128'd1);
    cyc();
    put(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t4_refill_count", 128'(count), 128'd8);
    out_bus.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_wrap_order", 128'(out_bus.uop), 128'(32'h41 + i));
      cyc();
    end
    chk("t4_empty", 128'(count), 128'd0);

    // flush discards a partial instruction and the flush-cycle push
    out_bus.ready = 1'b0;
    put(1'b1, 32'h51, 1'b0, 1'b0, 32'h500);
    cyc();
    put(1'b1, 32'h52, 1'b0, 1'b0, 32'h500);
    cyc();
    chk("t5_partial_count", 128'(count), 128'd2);
    chk("t5_partial_valid", 128'(out_bus.valid), 128'd0);
    put(1'b1, 32'h53, 1'b1, 1'b0, 32'h500);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t5_flush_count", 128'(count), 128'd0);
    chk("t5_flush_valid", 128'(out_bus.valid), 128'd0);
    chk("t5_flush_ready", 128'(in_bus.ready), 128'd1);
    put(1'b1, 32'h54, 1'b1, 1'b0, 32'h540);
    cyc();
    put(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t5_after_uop", 128'(out_bus.uop), 128'h54);
    out_bus.ready = 1'b1;
    cyc();
    out_bus.ready = 1'b0;

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 32'h61 + i, 1'b1, 1'b0, 32'h600);
      cyc();
    end
    put(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t6_pre_count", 128'(count), 128'd5);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_count", 128'(count), 128'd0);
    chk("t6_rst_valid", 128'(out_bus.valid), 128'd0);
    chk("t6_rst_ready", 128'(in_bus.ready), 128'd1);
    chk("t6_rst_uop", 128'(out_bus.uop), 128'd0);
    #2 rst = 1'b1;
    cyc();

    // simultaneous push and pop at count==1
    out_bus.ready = 1'b1;
    put(1'b1, 32'h81, 1'b1, 1'b0, 32'h800);
    cyc();
    chk("t7_one_count", 128'(count), 128'd1);
    put(1'b1, 32'h82, 1'b1, 1'b0, 32'h804);
    cyc();
    put(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t7_pp_count", 128'(count), 128'd1);
    chk("t7_pp_uop", 128'(out_bus.uop), 128'h82);
    cyc();
    chk("t7_empty", 128'(count), 128'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
